// File: rtl/product_feeder_pkg.sv
// Shared constants, state encoding and the signed lane multiply used by the
// product feeder.
package product_feeder_pkg;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int PW = 2 * DW;
  localparam int IW = $clog2(N);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Full-precision signed DW x DW product. Operands are sign-extended to PW
  // first, so the low PW bits of the product are exact.
  function automatic logic signed [PW-1:0] mul_s(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{DW{a[DW-1]}}, a};
    be = {{DW{b[DW-1]}}, b};
    return ae * be;
  endfunction

endpackage

// File: rtl/product_feeder_weight_regfile.sv
// Per-lane weight storage: N x DW, one write port, one combinational read
// port. A read in the same cycle as a write to that lane returns the old
// value, since the new value only lands at the clock edge.
module product_feeder_weight_regfile
  import product_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [N];

  // Weight array: cleared on reset, written on strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/product_feeder.sv
// Product feeder: collects N serial signed activations, multiplies each by
// its lane weight through one shared multiplier, and presents the N products
// as one vector with a valid/ready handshake and a wrapping neuron index.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting activations, cnt selects lane being written
// HOLD    | full vector presented on out_data, waiting for out_ready
module product_feeder
  import product_feeder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_we,
  input  logic [IW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*PW-1:0] out_data,
  output logic [IW-1:0]   out_idx
);

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q;
  logic [N-1:0][PW-1:0] prod_q;
  logic [DW-1:0]        w_rd;
  logic signed [PW-1:0] mult;
  logic                 accept;
  logic                 handshake;

  product_feeder_weight_regfile u_wrf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (cnt_q),
    .rdata (w_rd)
  );

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = out_valid && out_ready;
  assign mult      = mul_s(in_data, w_rd);

  // Next-state and lane counter: flush only acts while collecting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (flush) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == IW'(N - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and lane counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Product bank: one lane written per accepted activation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (accept) begin
      prod_q[cnt_q] <= mult;
    end
  end

  // Neuron index advances once per delivered vector, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (handshake) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign out_data = prod_q;
  assign out_idx  = idx_q;

endmodule
